// File: rtl/popcount_seq.sv
// Multi-cycle bit-count unit: popcount / zero-count / Hamming distance / parity,
// scanning CHUNK bits per cycle. Define HAM_DIST_EN to enable the a^b mode.
module popcount_seq_chunk #(
    parameter int CHUNK = 8,
    parameter int PW    = $clog2(CHUNK + 1)
) (
    input  logic [CHUNK-1:0] bits,
    output logic [PW-1:0]    cnt
);
    always_comb begin
        cnt = '0;
        for (int i = 0; i < CHUNK; i++) cnt = cnt + PW'(bits[i]);
    end
endmodule

module popcount_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] s
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = $clog2(WIDTH + 1);
    localparam int PW  = $clog2(CHUNK + 1);
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    acc;
    logic [IW-1:0]    idx;
    logic [1:0]       mode_q;
    logic [WIDTH-1:0] op;
    logic [PW-1:0]    chunk_cnt;
    logic [CW-1:0]    acc_nxt;

    // Operand selection happens once, at accept; the scan only ever sees shreg.
    always_comb begin
        op = a;
        case (mode)
            2'b01:   op = ~a;
`ifdef HAM_DIST_EN
            2'b10:   op = a ^ b;
`endif
            default: op = a;
        endcase
    end

`ifndef HAM_DIST_EN
    logic unused_b;
    assign unused_b = ^b;
`endif

    popcount_seq_chunk #(.CHUNK(CHUNK), .PW(PW)) u_chunk (
        .bits (shreg[CHUNK-1:0]),
        .cnt  (chunk_cnt)
    );

    assign acc_nxt = acc + CW'(chunk_cnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            s      <= '0;
            acc    <= '0;
            shreg  <= '0;
            idx    <= '0;
            mode_q <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        shreg  <= op;
                        acc    <= '0;
                        idx    <= '0;
                        mode_q <= mode;
                        state  <= S_RUN;
                        busy   <= 1'b1;
                    end else begin
                        state  <= S_IDLE;
                        busy   <= 1'b0;
                    end
                end
                S_RUN: begin
                    acc   <= acc_nxt;
                    shreg <= shreg >> CHUNK;
                    idx   <= idx + 1'b1;
                    if (idx == IW'(NCH - 1)) begin
                        // Parity is the LSB of the full count.
                        if (mode_q == 2'b11) s <= OUT_W'(acc_nxt[0]);
                        else                 s <= OUT_W'(acc_nxt);
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_popcount_seq.sv
// Directed bench for popcount_seq: main CHUNK=8 instance plus CHUNK=32 and CHUNK=1.
module tb_popcount_seq;
    logic        clk = 1'b0;
    logic        rst, start, start32, start1;
    logic [1:0]  mode;
    logic [31:0] a, b;
    logic        busy, done, busy32, done32, busy1, done1;
    logic [31:0] s, s32, s1;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    popcount_seq #(.WIDTH(32), .CHUNK(8), .OUT_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b),
        .busy(busy), .done(done), .s(s));
    popcount_seq #(.WIDTH(32), .CHUNK(32), .OUT_W(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .mode(mode), .a(a), .b(b),
        .busy(busy32), .done(done32), .s(s32));
    popcount_seq #(.WIDTH(32), .CHUNK(1), .OUT_W(32)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .mode(mode), .a(a), .b(b),
        .busy(busy1), .done(done1), .s(s1));

    // Drive one op on the main instance from a negedge; return on the negedge
    // where done is seen. lat counts negedges after the start edge (0 = timeout).
    task automatic run_op(input logic [1:0] m, input logic [31:0] va, input logic [31:0] vb,
                          output int lat, output int bcnt, output logic [31:0] res);
        lat = 0; bcnt = 0; res = '0;
        mode = m; a = va; b = vb; start = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (busy) bcnt++;
            if (done) begin
                lat = n; res = s;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 0; start32 = 0; start1 = 0; mode = 0; a = 0; b = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks += 3;
        if (s !== 32'd0)  begin errors++; $display("FAIL reset_s: got %0d expected 0", s); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    endtask

    task automatic test_popcount;
        int lat, bc; logic [31:0] r;
        run_op(2'b00, 32'hFFFFFFFF, 32'h0, lat, bc, r);
        checks += 3;
        if (lat != 5)   begin errors++; $display("FAIL ones_latency: got %0d expected 5", lat); end
        if (bc != 4)    begin errors++; $display("FAIL ones_busy_cycles: got %0d expected 4", bc); end
        if (r !== 32'd32) begin errors++; $display("FAIL ones_s: got %0d expected 32", r); end
    endtask

    // Ops start on the done negedge of the previous op, so these run back-to-back.
    task automatic test_back_to_back;
        int lat, bc; logic [31:0] r;
        run_op(2'b01, 32'h00000000, 32'h0, lat, bc, r);
        checks += 2;
        if (lat != 5)     begin errors++; $display("FAIL zeros_latency: got %0d expected 5", lat); end
        if (r !== 32'd32) begin errors++; $display("FAIL zeros_s: got %0d expected 32", r); end
        run_op(2'b00, 32'h80000001, 32'h0, lat, bc, r);
        checks += 2;
        if (lat != 5)    begin errors++; $display("FAIL edge_bits_latency: got %0d expected 5", lat); end
        if (r !== 32'd2) begin errors++; $display("FAIL edge_bits_s: got %0d expected 2", r); end
    endtask

    task automatic test_ham;
        int lat, bc; logic [31:0] r, exp_s;
`ifdef HAM_DIST_EN
        exp_s = 32'd32;
`else
        exp_s = 32'd16;
`endif
        run_op(2'b10, 32'hF0F0F0F0, 32'h0F0F0F0F, lat, bc, r);
        checks += 1;
        if (r !== exp_s) begin errors++; $display("FAIL ham_s: got %0d expected %0d", r, exp_s); end
    endtask

    task automatic test_parity;
        int lat, bc; logic [31:0] r;
        run_op(2'b11, 32'h00000007, 32'h0, lat, bc, r);
        checks += 2;
        if (lat != 5)    begin errors++; $display("FAIL parity_latency: got %0d expected 5", lat); end
        if (r !== 32'd1) begin errors++; $display("FAIL parity_odd_s: got %0d expected 1", r); end
        run_op(2'b11, 32'h00000003, 32'h0, lat, bc, r);
        checks += 1;
        if (r !== 32'd0) begin errors++; $display("FAIL parity_even_s: got %0d expected 0", r); end
    endtask

    // a at the j-th edge has j+1 ones; accepts land on edges 0, 5, 10.
    task automatic test_start_hold;
        logic [31:0] got [0:3];
        int nd = 0;
        mode = 2'b00; a = 32'h1; start = 1'b1;
        for (int n = 1; n <= 25; n++) begin
            @(negedge clk);
            if (n < 12) a = (32'h1 << (n + 1)) - 32'h1;
            else start = 1'b0;
            if (done && nd < 4) begin got[nd] = s; nd++; end
        end
        checks += 4;
        if (nd != 3) begin errors++; $display("FAIL hold_done_count: got %0d expected 3", nd); end
        if (nd > 0 && got[0] !== 32'd1)  begin errors++; $display("FAIL hold_s0: got %0d expected 1", got[0]); end
        if (nd > 1 && got[1] !== 32'd6)  begin errors++; $display("FAIL hold_s1: got %0d expected 6", got[1]); end
        if (nd > 2 && got[2] !== 32'd11) begin errors++; $display("FAIL hold_s2: got %0d expected 11", got[2]); end
    endtask

    task automatic test_abort;
        int seen = 0;
        mode = 2'b00; a = 32'hFFFFFFFF; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (done) seen++;
        end
        checks += 3;
        if (seen != 0)     begin errors++; $display("FAIL abort_done: got %0d pulses expected 0", seen); end
        if (s !== 32'd0)   begin errors++; $display("FAIL abort_s: got %0d expected 0", s); end
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    endtask

    task automatic test_chunk_sizes;
        int lat = 0; logic [31:0] r = '0;
        mode = 2'b00; a = 32'h0000FFFF; start32 = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1) start32 = 1'b0;
            if (done32) begin lat = n; r = s32; break; end
        end
        checks += 2;
        if (lat != 2)     begin errors++; $display("FAIL chunk32_latency: got %0d expected 2", lat); end
        if (r !== 32'd16) begin errors++; $display("FAIL chunk32_s: got %0d expected 16", r); end
        lat = 0; r = '0;
        start1 = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (n == 1) start1 = 1'b0;
            if (done1) begin lat = n; r = s1; break; end
        end
        checks += 2;
        if (lat != 33)    begin errors++; $display("FAIL chunk1_latency: got %0d expected 33", lat); end
        if (r !== 32'd16) begin errors++; $display("FAIL chunk1_s: got %0d expected 16", r); end
    endtask

    initial begin
        test_reset;
        test_popcount;
        test_back_to_back;
        test_ham;
        test_parity;
        test_start_hold;
        test_abort;
        test_chunk_sizes;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
